// File: rtl/synapse_accumulator_if.sv
// Spike-vector handshake and current-pulse bundle
// between the spike source, the accumulator and the neuron.
interface synapse_accumulator_if #(
  parameter int N_SYN     = 8,
  parameter int CUR_WIDTH = 8
);
  logic [N_SYN-1:0]     in_spikes;
  logic                 in_valid;
  logic                 in_ready;
  logic [CUR_WIDTH-1:0] current;
  logic                 current_valid;
  logic                 sat;

  modport master (
    output in_spikes,
    output in_valid,
    input  in_ready,
    input  current,
    input  current_valid,
    input  sat
  );

  modport slave (
    input  in_spikes,
    input  in_valid,
    output in_ready,
    output current,
    output current_valid,
    output sat
  );
endinterface

// File: rtl/synapse_accumulator.sv
// Serial weighted spike summation, one synapse per cycle,
// saturating, emitted as a one-cycle current pulse.
module synapse_accumulator #(
  parameter int N_SYN     = 8,
  parameter int W_WIDTH   = 8,
  parameter int CUR_WIDTH = 8,
  parameter int ADDR_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [W_WIDTH-1:0] cfg_wdata,
  synapse_accumulator_if.slave bus,
  output logic               busy
);

  localparam int IDX_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam int SW =
    ((W_WIDTH > CUR_WIDTH) ? W_WIDTH : CUR_WIDTH) + 1;
  localparam logic [CUR_WIDTH:0] MAX =
    {1'b0, {CUR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CUR_WIDTH:0]   acc_q, acc_d;
  logic [N_SYN-1:0]     spk_q, spk_d;
  logic                 stk_q, stk_d;
  logic [W_WIDTH-1:0]   w_q [N_SYN];
  logic [W_WIDTH-1:0]   w_d [N_SYN];
  logic [CUR_WIDTH-1:0] cur_q, cur_d;
  logic                 cv_q, cv_d;
  logic                 sat_q, sat_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic [SW-1:0]        sum;

  // Wide sum: an oversized weight overflows MAX and clamps too
  assign sum = SW'(acc_q) + SW'(w_q[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    spk_d   = spk_q;
    stk_d   = stk_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    cv_d    = 1'b0;
    cur_d   = '0;
    sat_d   = 1'b0;
    for (int k = 0; k < N_SYN; k++) begin
      w_d[k] = w_q[k];
      if (cfg_we && cfg_addr == ADDR_W'(k))
        w_d[k] = cfg_wdata;
    end
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && rdy_q) begin
          spk_d   = bus.in_spikes;
          acc_d   = '0;
          idx_d   = '0;
          stk_d   = 1'b0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (spk_q[idx_q]) begin
          if (sum > SW'(MAX)) begin
            acc_d = MAX;
            stk_d = 1'b1;
          end else begin
            acc_d = sum[CUR_WIDTH:0];
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_SYN - 1)) begin
          state_d = OUT;
          cv_d    = 1'b1;
          cur_d   = acc_d[CUR_WIDTH-1:0];
          sat_d   = stk_d;
        end
      end
      OUT: begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      spk_q   <= '0;
      stk_q   <= 1'b0;
      w_q     <= '{default: '0};
      cur_q   <= '0;
      cv_q    <= 1'b0;
      sat_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      stk_q   <= stk_d;
      w_q     <= w_d;
      cur_q   <= cur_d;
      cv_q    <= cv_d;
      sat_q   <= sat_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready      = rdy_q;
  assign bus.current       = cur_q;
  assign bus.current_valid = cv_q;
  assign bus.sat           = sat_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Scoreboard bench for synapse_accumulator: event-level
// reference model, decoupled monitor, directed + random.
module tb_synapse_accumulator;

  localparam int N = 8;

  typedef struct {
    int cur;
    int sat;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       busy;

  synapse_accumulator_if #(.N_SYN(N), .CUR_WIDTH(8)) bus ();

  synapse_accumulator #(
    .N_SYN(N), .W_WIDTH(8), .CUR_WIDTH(8), .ADDR_W(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .bus       (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int       cyc = 0;
  int       n_cmp = 0;
  int       n_bad = 0;
  int       w_m [N];
  int       m_total = 0;
  int       m_acc_cyc = 0;
  int       m_next_ready = 0;
  int       m_k = 0;
  logic     m_active = 1'b0;
  logic     m_live = 1'b0;
  logic [N-1:0] m_spk = '0;
  exp_t     sb [$];
  exp_t     m_e;
  exp_t     mon_e;
  int       last_cur = -1;
  int       last_sat = -1;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  // Reference model: weight k of a pass accepted in cycle c
  // is the value held during cycle c+1+k; result = min(sum,255)
  initial begin
    foreach (w_m[k]) w_m[k] = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        foreach (w_m[k]) w_m[k] = 0;
        m_active     = 1'b0;
        m_next_ready = cyc + 1;
        m_live       = 1'b0;
        sb.delete();
      end else begin
        m_live = 1'b1;
        if (m_active && cyc > m_acc_cyc &&
            cyc <= m_acc_cyc + N) begin
          m_k = cyc - m_acc_cyc - 1;
          if (m_spk[m_k]) m_total += w_m[m_k];
          if (m_k == N - 1) begin
            m_e.cur = (m_total > 255) ? 255 : m_total;
            m_e.sat = (m_total > 255) ? 1 : 0;
            m_e.cyc = m_acc_cyc + N + 1;
            sb.push_back(m_e);
            m_active = 1'b0;
          end
        end
        if (bus.in_valid && cyc >= m_next_ready) begin
          m_acc_cyc    = cyc;
          m_spk        = bus.in_spikes;
          m_total      = 0;
          m_active     = 1'b1;
          m_next_ready = cyc + N + 2;
        end
        if (cfg_we && int'(cfg_addr) < N)
          w_m[cfg_addr] = int'(cfg_wdata);
      end
      cyc++;
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("in_ready", int'(bus.in_ready),
            (cyc >= m_next_ready) ? 1 : 0);
        chk("busy", int'(busy),
            (cyc < m_next_ready) ? 1 : 0);
        if (bus.current_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid",
                int'(bus.current_valid), 0);
          end else begin
            mon_e = sb.pop_front();
            chk("current", int'(bus.current), mon_e.cur);
            chk("sat", int'(bus.sat), mon_e.sat);
            chk("result_cycle", cyc, mon_e.cyc);
            last_cur = int'(bus.current);
            last_sat = int'(bus.sat);
          end
        end else begin
          chk("idle_current", int'(bus.current), 0);
          chk("idle_sat", int'(bus.sat), 0);
          if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missing_valid",
                int'(bus.current_valid), 1);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic wr(int a, int d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_wdata = 8'(d);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic send(logic [7:0] s);
    bit   ok;
    logic r;
    ok = 1'b0;
    bus.in_spikes = s;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = bus.in_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", int'(bus.in_ready), 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      #1;
      if (sb.size() == 0 && !m_active &&
          cyc >= m_next_ready) return;
      @(negedge clk);
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic expect_last(string nm, int c, int s);
    chk(nm, last_cur, c);
    chk({nm, "_sat"}, last_sat, s);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_spikes = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) wr(k, 10 * (k + 1));
    send(8'h05);
    wait_done();
    expect_last("pair_sum", 40, 0);

    for (int k = 0; k < N; k++) wr(k, 100);
    send(8'hFF);
    wait_done();
    expect_last("saturate", 255, 1);
    send(8'h03);
    wait_done();
    expect_last("no_sat", 200, 0);

    send(8'h00);
    wait_done();
    expect_last("zero_vec", 0, 0);

    // Hold a new vector through the busy window
    send(8'h01);
    bus.in_spikes = 8'h06;
    bus.in_valid  = 1'b1;
    repeat (10) @(negedge clk);
    bus.in_valid  = 1'b0;
    wait_done();
    expect_last("held_vec", 200, 0);

    for (int k = 0; k < N; k++) wr(k, 0);
    wr(0, 5);
    wr(7, 5);
    send(8'h81);
    repeat (2) @(negedge clk);
    wr(7, 50);
    wait_done();
    expect_last("late_write", 55, 0);
    wr(7, 5);
    send(8'h81);
    repeat (2) @(negedge clk);
    wr(0, 50);
    wait_done();
    expect_last("used_write", 10, 0);

    // Write coincident with the handshake
    for (int k = 0; k < N; k++) wr(k, 0);
    cfg_we    = 1'b1;
    cfg_addr  = 3'd0;
    cfg_wdata = 8'd77;
    send(8'h01);
    cfg_we    = 1'b0;
    wait_done();
    expect_last("hs_write", 77, 0);

    // Reset mid-pass
    for (int k = 0; k < N; k++) wr(k, 20);
    send(8'hFF);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'hFF);
    wait_done();
    expect_last("post_reset", 0, 0);

    repeat (500) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_spikes = 8'($urandom);
      cfg_we        = ($urandom_range(0, 3) == 0);
      cfg_addr      = 3'($urandom);
      cfg_wdata     = ($urandom_range(0, 1) == 1)
                      ? 8'($urandom_range(0, 40))
                      : 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    cfg_we       = 1'b0;
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
